// File: rtl/dcache_2way.sv
// dcache_2way: 2-way set-associative, write-back, write-allocate data cache
// with 4-word (128-bit) blocks in front of a slow block memory.
//
// Ports
//   clk, proc_reset         rising-edge clock, async active-high reset
//   proc_read/proc_write    word request (both high = write)
//   proc_addr[29:0]         {tag, index, word offset[1:0]}
//   proc_wdata/proc_rdata   write data / read data (0 unless read hit)
//   proc_stall              processor must hold request
//   mem_read/mem_write      block refill / write-back request
//   mem_addr[27:0]          block address {tag, index}
//   mem_wdata/mem_rdata     128-bit blocks, word 0 in [31:0]
//   mem_ready               one-cycle completion pulse from memory
//
// Build option: DCACHE_LRU_EN selects true per-set LRU replacement;
// otherwise a single global round-robin bit toggles on every refill.
module dcache_2way #(
  parameter int SETS = 8
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 28 - IW;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;
  state_e state_q, state_d;

  logic [1:0][SETS-1:0] valid_q, dirty_q;
  logic [TW-1:0]        tag_q  [2][SETS];
  logic [127:0]         data_q [2][SETS];

  // miss context captured when leaving IDLE
  logic [IW-1:0] idx_q;
  logic [TW-1:0] mtag_q;
  logic          vic_q;

  logic [1:0]    off;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          req, hit0, hit1, hit, hit_way, victim, repl_sel;
  logic          miss_start, wr_hit, any_hit, refill;

  assign off = proc_addr[1:0];
  assign idx = proc_addr[IW+1:2];
  assign tag = proc_addr[29:IW+2];

  assign req     = proc_read | proc_write;
  assign hit0    = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1    = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit     = hit0 | hit1;
  assign hit_way = ~hit0;  // only meaningful when hit

  assign any_hit    = (state_q == IDLE) && req && hit;
  assign wr_hit     = any_hit && proc_write;
  assign miss_start = (state_q == IDLE) && req && !hit;
  assign refill     = (state_q == ALLOCATE) && mem_ready;

  // read data is forced to zero unless this is a pure read that hits
  assign proc_rdata = (any_hit && !proc_write) ?
                      data_q[hit_way][idx][{off, 5'd0} +: 32] : 32'h0;

  // invalid ways are filled first (way 0 preferred) before evicting
  always_comb begin
    if (!valid_q[0][idx])      victim = 1'b0;
    else if (!valid_q[1][idx]) victim = 1'b1;
    else                       victim = repl_sel;
  end

`ifdef DCACHE_LRU_EN
  // lru_q[s] names the least-recently-used way of set s
  logic [SETS-1:0] lru_q;
  assign repl_sel = lru_q[idx];
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset)   lru_q <= '0;
    else if (refill)  lru_q[idx_q] <= ~vic_q;
    else if (any_hit) lru_q[idx] <= ~hit_way;
  end
`else
  logic rr_q;
  assign repl_sel = rr_q;
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset)  rr_q <= 1'b0;
    else if (refill) rr_q <= ~rr_q;
  end
`endif

  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: if (miss_start) begin
        proc_stall = 1'b1;
        state_d    = (valid_q[victim][idx] && dirty_q[victim][idx]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {tag_q[vic_q][idx_q], idx_q};
        mem_wdata  = data_q[vic_q][idx_q];
        if (mem_ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = {mtag_q, idx_q};
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // while reset is held, valid bits are clear so a pending request would
    // look like a miss; keep the processor unstalled instead
    if (proc_reset) proc_stall = 1'b0;
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      idx_q   <= '0;
      mtag_q  <= '0;
      vic_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        idx_q  <= idx;
        mtag_q <= tag;
        vic_q  <= victim;
      end
      if (wr_hit) dirty_q[hit_way][idx] <= 1'b1;
      if (refill) begin
        valid_q[vic_q][idx_q] <= 1'b1;
        dirty_q[vic_q][idx_q] <= 1'b0;
      end
    end
  end

  // tag/data arrays carry no reset; the valid bits qualify them
  always_ff @(posedge clk) begin
    if (refill) begin
      data_q[vic_q][idx_q] <= mem_rdata;
      tag_q[vic_q][idx_q]  <= mtag_q;
    end else if (wr_hit) begin
      data_q[hit_way][idx][{off, 5'd0} +: 32] <= proc_wdata;
    end
  end
endmodule

// File: tb/tb_dcache_2way.sv
// Directed bench for dcache_2way (SETS=8: offset [1:0], index [4:2], tag [29:5]).
module tb_dcache_2way;
  logic         clk = 1'b0;
  logic         proc_reset = 1'b1;
  logic         proc_read = 1'b0, proc_write = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic [31:0]  proc_rdata;
  logic         proc_stall, mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  int cmp = 0;
  int err = 0;

  logic [127:0] blk_a  = {32'hD0D0D0D0, 32'hC0C0C0C0, 32'hB0B0B0B0, 32'hA0A0A0A0};
  logic [127:0] blk_e  = {32'hE3E3E3E3, 32'hE2E2E2E2, 32'hE1E1E1E1, 32'hE0E0E0E0};
  logic [127:0] blk_f  = {32'hF3F3F3F3, 32'hF2F2F2F2, 32'hF1F1F1F1, 32'hF0F0F0F0};
  logic [127:0] blk_t0 = {32'h10000003, 32'h10000002, 32'h10000001, 32'h10000000};
  logic [127:0] blk_t1 = {32'h20000003, 32'h20000002, 32'h20000001, 32'h20000000};
  logic [127:0] blk_t2 = {32'h30000003, 32'h30000002, 32'h30000001, 32'h30000000};

  dcache_2way #(.SETS(8)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_rdata(proc_rdata), .proc_stall(proc_stall),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // advance to 1 time unit past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one-cycle memory completion carrying blk
  task automatic mem_respond(input logic [127:0] blk);
    mem_rdata = blk;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    proc_read = 1'b1; proc_addr = 30'h10;
    tick(); tick();
    #1;
    cmp++; if (proc_stall !== 1'b0) begin err++; $display("FAIL rst_stall got=%h exp=0", proc_stall); end
    cmp++; if (mem_read !== 1'b0) begin err++; $display("FAIL rst_mem_read got=%h exp=0", mem_read); end
    cmp++; if (mem_write !== 1'b0) begin err++; $display("FAIL rst_mem_write got=%h exp=0", mem_write); end
    cmp++; if (mem_addr !== 28'h0) begin err++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    cmp++; if (mem_wdata !== 128'h0) begin err++; $display("FAIL rst_mem_wdata got=%h exp=0", mem_wdata); end
    cmp++; if (proc_rdata !== 32'h0) begin err++; $display("FAIL rst_rdata got=%h exp=0", proc_rdata); end
    proc_reset = 1'b0; proc_read = 1'b0;
    #1;
    cmp++; if (proc_stall !== 1'b0) begin err++; $display("FAIL idle_noreq_stall got=%h exp=0", proc_stall); end
    tick();
  endtask

  task automatic test_read_miss();
    int bad;
    proc_read = 1'b1; proc_addr = 30'h10;
    #1;
    cmp++; if (proc_stall !== 1'b1) begin err++; $display("FAIL miss_stall got=%h exp=1", proc_stall); end
    tick();
    cmp++; if (mem_read !== 1'b1) begin err++; $display("FAIL alloc_mem_read got=%h exp=1", mem_read); end
    cmp++; if (mem_write !== 1'b0) begin err++; $display("FAIL alloc_mem_write got=%h exp=0", mem_write); end
    cmp++; if (mem_addr !== 28'h4) begin err++; $display("FAIL alloc_mem_addr got=%h exp=4", mem_addr); end
    bad = 0;
    repeat (20) begin
      tick();
      if (mem_read !== 1'b1 || proc_stall !== 1'b1 || mem_addr !== 28'h4) bad++;
    end
    cmp++; if (bad !== 0) begin err++; $display("FAIL alloc_hold bad_cycles got=%0d exp=0", bad); end
    mem_respond(blk_a);
    cmp++; if (proc_stall !== 1'b0) begin err++; $display("FAIL refill_stall got=%h exp=0", proc_stall); end
    cmp++; if (proc_rdata !== 32'hA0A0A0A0) begin err++; $display("FAIL refill_rdata got=%h exp=a0a0a0a0", proc_rdata); end
    cmp++; if (mem_read !== 1'b0) begin err++; $display("FAIL refill_mem_read got=%h exp=0", mem_read); end
    tick();
  endtask

  task automatic test_write_hit();
    proc_read = 1'b0; proc_write = 1'b1; proc_addr = 30'h12; proc_wdata = 32'hDEADBEEF;
    mem_ready = 1'b1;  // stray pulse while idle must be ignored
    #1;
    cmp++; if (proc_stall !== 1'b0) begin err++; $display("FAIL wr_hit_stall got=%h exp=0", proc_stall); end
    cmp++; if (proc_rdata !== 32'h0) begin err++; $display("FAIL wr_rdata got=%h exp=0", proc_rdata); end
    tick();
    mem_ready = 1'b0;
    cmp++; if ({mem_read, mem_write} !== 2'b00) begin err++; $display("FAIL stray_ready got=%b exp=00", {mem_read, mem_write}); end
    // read and write together behave as a write
    proc_read = 1'b1; proc_addr = 30'h13; proc_wdata = 32'h12345678;
    #1;
    cmp++; if (proc_rdata !== 32'h0) begin err++; $display("FAIL rdwr_rdata got=%h exp=0", proc_rdata); end
    cmp++; if (proc_stall !== 1'b0) begin err++; $display("FAIL rdwr_stall got=%h exp=0", proc_stall); end
    tick();
    proc_write = 1'b0; proc_addr = 30'h12;
    #1;
    cmp++; if (proc_rdata !== 32'hDEADBEEF) begin err++; $display("FAIL rd_after_wr got=%h exp=deadbeef", proc_rdata); end
    proc_addr = 30'h11;
    #1;
    cmp++; if (proc_rdata !== 32'hB0B0B0B0) begin err++; $display("FAIL rd_neighbour got=%h exp=b0b0b0b0", proc_rdata); end
    proc_addr = 30'h13;
    #1;
    cmp++; if (proc_rdata !== 32'h12345678) begin err++; $display("FAIL rd_rdwr got=%h exp=12345678", proc_rdata); end
    tick();
  endtask

  task automatic test_writeback();
    proc_read = 1'b1; proc_addr = 30'h30;  // tag 1, set 4 -> fills way 1
    #1;
    cmp++; if (proc_stall !== 1'b1) begin err++; $display("FAIL t1_stall got=%h exp=1", proc_stall); end
    tick();
    cmp++; if ({mem_read, mem_write} !== 2'b10) begin err++; $display("FAIL t1_clean_alloc got=%b exp=10", {mem_read, mem_write}); end
    cmp++; if (mem_addr !== 28'hC) begin err++; $display("FAIL t1_mem_addr got=%h exp=c", mem_addr); end
    mem_respond(blk_e);
    cmp++; if (proc_rdata !== 32'hE0E0E0E0) begin err++; $display("FAIL t1_rdata got=%h exp=e0e0e0e0", proc_rdata); end
    tick();
    proc_addr = 30'h50;  // tag 2, set 4 -> evicts dirty way 0
    #1;
    cmp++; if (proc_stall !== 1'b1) begin err++; $display("FAIL t2_stall got=%h exp=1", proc_stall); end
    tick();
    cmp++; if ({mem_read, mem_write} !== 2'b01) begin err++; $display("FAIL wb_rw got=%b exp=01", {mem_read, mem_write}); end
    cmp++; if (mem_addr !== 28'h4) begin err++; $display("FAIL wb_mem_addr got=%h exp=4", mem_addr); end
    cmp++; if (mem_wdata !== {32'h12345678, 32'hDEADBEEF, 32'hB0B0B0B0, 32'hA0A0A0A0}) begin
      err++; $display("FAIL wb_mem_wdata got=%h exp=12345678deadbeefb0b0b0b0a0a0a0a0", mem_wdata); end
    mem_respond(128'h0);
    cmp++; if ({mem_read, mem_write} !== 2'b10) begin err++; $display("FAIL wb_then_alloc got=%b exp=10", {mem_read, mem_write}); end
    cmp++; if (mem_addr !== 28'h14) begin err++; $display("FAIL t2_mem_addr got=%h exp=14", mem_addr); end
    cmp++; if (proc_stall !== 1'b1) begin err++; $display("FAIL wb_alloc_stall got=%h exp=1", proc_stall); end
    mem_respond(blk_f);
    cmp++; if (proc_rdata !== 32'hF0F0F0F0) begin err++; $display("FAIL t2_rdata got=%h exp=f0f0f0f0", proc_rdata); end
    tick();
    proc_addr = 30'h31;
    #1;
    cmp++; if (proc_rdata !== 32'hE1E1E1E1) begin err++; $display("FAIL t1_kept got=%h exp=e1e1e1e1", proc_rdata); end
    tick();
  endtask

  task automatic test_reset_alloc();
    proc_read = 1'b1; proc_addr = 30'h10;  // tag 0 was evicted: miss, clean victim
    tick();
    cmp++; if ({mem_read, mem_write} !== 2'b10) begin err++; $display("FAIL ra_alloc got=%b exp=10", {mem_read, mem_write}); end
    proc_reset = 1'b1;
    #1;
    cmp++; if (mem_read !== 1'b0) begin err++; $display("FAIL ra_mem_read got=%h exp=0", mem_read); end
    cmp++; if (proc_stall !== 1'b0) begin err++; $display("FAIL ra_stall got=%h exp=0", proc_stall); end
    cmp++; if (mem_addr !== 28'h0) begin err++; $display("FAIL ra_mem_addr got=%h exp=0", mem_addr); end
    tick();
    proc_reset = 1'b0;
    #1;
    cmp++; if (proc_stall !== 1'b1) begin err++; $display("FAIL ra_remiss_stall got=%h exp=1", proc_stall); end
    tick();
    cmp++; if (mem_read !== 1'b1 || mem_addr !== 28'h4) begin err++; $display("FAIL ra_remiss_mem got=%h/%h exp=1/4", mem_read, mem_addr); end
    // clear again so the replacement bits start from zero
    proc_reset = 1'b1; proc_read = 1'b0;
    tick();
    proc_reset = 1'b0;
    tick();
  endtask

  task automatic test_replacement();
    logic [29:0] surv_a, evic_a;
    logic [31:0] surv_w;
    logic [27:0] evic_m;
    proc_read = 1'b1; proc_addr = 30'h24;  // T0: tag 1, set 1
    tick();
    cmp++; if (mem_addr !== 28'h9) begin err++; $display("FAIL t0_mem_addr got=%h exp=9", mem_addr); end
    mem_respond(blk_t0);
    tick();
    proc_addr = 30'h44;                    // T1: tag 2, set 1
    tick();
    cmp++; if (mem_addr !== 28'h11) begin err++; $display("FAIL t1b_mem_addr got=%h exp=11", mem_addr); end
    mem_respond(blk_t1);
    tick();
    proc_addr = 30'h24;                    // T0 again
    #1;
    cmp++; if (proc_stall !== 1'b0 || proc_rdata !== 32'h10000000) begin
      err++; $display("FAIL t0_rehit got=%h/%h exp=0/10000000", proc_stall, proc_rdata); end
    tick();
    proc_addr = 30'h64;                    // T2: tag 3, set 1
    tick();
    cmp++; if ({mem_read, mem_write} !== 2'b10 || mem_addr !== 28'h19) begin
      err++; $display("FAIL t2b_alloc got=%b/%h exp=10/19", {mem_read, mem_write}, mem_addr); end
    mem_respond(blk_t2);
    cmp++; if (proc_rdata !== 32'h30000000) begin err++; $display("FAIL t2b_rdata got=%h exp=30000000", proc_rdata); end
    tick();
`ifdef DCACHE_LRU_EN
    surv_a = 30'h24; surv_w = 32'h10000000; evic_a = 30'h44; evic_m = 28'h11;
`else
    surv_a = 30'h44; surv_w = 32'h20000000; evic_a = 30'h24; evic_m = 28'h9;
`endif
    proc_addr = surv_a;
    #1;
    cmp++; if (proc_stall !== 1'b0 || proc_rdata !== surv_w) begin
      err++; $display("FAIL repl_survivor got=%h/%h exp=0/%h", proc_stall, proc_rdata, surv_w); end
    tick();
    proc_addr = evic_a;
    #1;
    cmp++; if (proc_stall !== 1'b1) begin err++; $display("FAIL repl_evicted_stall got=%h exp=1", proc_stall); end
    tick();
    cmp++; if (mem_addr !== evic_m) begin err++; $display("FAIL repl_evicted_addr got=%h exp=%h", mem_addr, evic_m); end
    mem_respond(128'h0);
    cmp++; if (proc_stall !== 1'b0) begin err++; $display("FAIL repl_refill_stall got=%h exp=0", proc_stall); end
    proc_read = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write_hit();
    test_writeback();
    test_reset_alloc();
    test_replacement();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

  // cap runtime should anything hang
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dcache_2way.md
DCACHE_2WAY -- requirements
Module: dcache_2way

Interface
REQ-001 SHALL have parameter SETS, default 8, number of sets; power of two in 2..64; index width IW = log2(SETS).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port proc_reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port proc_read  input  1  processor word read request.
REQ-005 SHALL have port proc_write  input  1  processor word write request.
REQ-006 SHALL have port proc_addr  input  30  word address: [1:0] word offset, [IW+1:2] index, [29:IW+2] tag.
REQ-007 SHALL have port proc_wdata  input  32  write data.
REQ-008 SHALL have port proc_rdata  output  32  read data.
REQ-009 SHALL have port proc_stall  output  1  processor must hold its request and pipeline.
REQ-010 SHALL have port mem_read  output  1  block read request to slow memory.
REQ-011 SHALL have port mem_write  output  1  block write request to slow memory.
REQ-012 SHALL have port mem_addr  output  28  block address {tag,index}.
REQ-013 SHALL have port mem_wdata  output  128  write-back block, word 0 in [31:0].
REQ-014 SHALL have port mem_rdata  input  128  refill block, word 0 in [31:0].
REQ-015 SHALL have port mem_ready  input  1  one-cycle completion pulse from slow memory.

Function
REQ-016 SHALL be 2-way set-associative, write-back, write-allocate; 4-word blocks; per line: valid, dirty, tag, 128-bit data; per set: one replacement bit.
REQ-017 SHALL use FSM states IDLE, WRITEBACK, ALLOCATE; outputs mem_read/mem_write/mem_addr/mem_wdata decoded from state register and latched victim/miss info only.
REQ-018 In IDLE, hit (valid and tag match in either way) SHALL give proc_stall=0 combinationally, same cycle.
REQ-019 Read hit SHALL drive proc_rdata with the addressed word combinationally; proc_rdata SHALL be 0 whenever no read hit.
REQ-020 Write hit SHALL update the addressed word and set dirty at the clock edge; other words unchanged.
REQ-021 Any hit SHALL mark the hit way most-recently-used for that set.
REQ-022 Miss in IDLE SHALL assert proc_stall the same cycle; victim = invalid way (way 0 preferred), else replacement-selected way.
REQ-023 Miss with dirty valid victim SHALL go to WRITEBACK: mem_write=1, mem_addr={victim tag,index}, mem_wdata=victim block, until clock edge with mem_ready=1, then ALLOCATE.
REQ-024 Miss with clean or invalid victim SHALL go directly to ALLOCATE.
REQ-025 ALLOCATE SHALL drive mem_read=1, mem_addr={request tag,index} until edge with mem_ready=1; at that edge write mem_rdata into victim way, valid=1, dirty=0, tag set, then IDLE.
REQ-026 After refill, the retried request SHALL hit in IDLE (stall falls, write then merges and sets dirty).
REQ-027 proc_stall SHALL stay 1 throughout WRITEBACK and ALLOCATE; mem_read and mem_write SHALL never be 1 together.
REQ-028 proc_read and proc_write both 1 SHALL be treated as write; neither SHALL leave all state unchanged with proc_stall=0.
REQ-029 mem_ready outside WRITEBACK/ALLOCATE SHALL be ignored.

Reset
REQ-030 proc_reset=1 SHALL immediately clear all valid, dirty and replacement bits, force IDLE, drive mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, proc_stall=0, proc_rdata=0.
REQ-031 Reset mid-WRITEBACK/ALLOCATE SHALL abandon the transaction; no data array write occurs; dirty data is lost.

Configuration
REQ-032 With DCACHE_LRU_EN defined, replacement bit SHALL be true LRU per set (updated on every hit and refill).
REQ-033 Without DCACHE_LRU_EN, SHALL use one global round-robin bit toggling on every refill; hits SHALL not change it.

Verification
REQ-034 Reset, read addr 0x10 -> stall=1, mem_read=1 mem_addr=0x4; mem_ready with block {D,C,B,A} -> next cycle stall=0, proc_rdata=A.
REQ-035 Write 0x12 data 0xDEADBEEF after refill -> stall=0 same cycle; subsequent read 0x12 returns 0xDEADBEEF, dirty set.
REQ-036 Fill both ways of set 4 (SETS=8), dirty way, third tag to set 4 -> mem_write=1 with old block and old {tag,index} before mem_read; written data appears in mem_wdata.
REQ-037 DCACHE_LRU_EN: access tag T0, T1, T0 in one set, then miss T2 -> T1 way replaced; without macro -> way per round-robin bit.
REQ-038 Assert proc_reset during ALLOCATE -> mem_read drops same cycle; re-read same address misses again.
REQ-039 mem_ready held 0 for 20 cycles in ALLOCATE -> mem_read and stall stay 1, no state change.
